// File: rtl/xilinx_sdpram_be.sv
// Single-clock simple dual-port RAM with byte-enable writes, optional write-to-read bypass,
// configurable read latency with output valid, and an optional post-reset clear sequencer.
module xilinx_sdpram_be #(
  parameter int                 RAM_WIDTH  = 32,
  parameter int                 RAM_DEEP   = 10,
  parameter int                 BYTE_W     = 8,
  parameter int                 RD_LATENCY = 1,
  parameter int                 BYPASS_EN  = 1,
  parameter int                 INIT_CLR   = 1,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk_rd,
  input  logic                          reset,
  output logic                          init_done,
  input  logic                          wren,
  input  logic [RAM_DEEP-1:0]           wraddress,
  input  logic [RAM_WIDTH/BYTE_W-1:0]   wrbe,
  input  logic [RAM_WIDTH-1:0]          data,
  input  logic                          rden,
  input  logic [RAM_DEEP-1:0]           rdaddress,
  output logic [RAM_WIDTH-1:0]          q,
  output logic                          q_vld
);

  localparam int NBE = RAM_WIDTH / BYTE_W;

  if ((RAM_WIDTH % BYTE_W) != 0 || RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_param
    $error("xilinx_sdpram_be: RAM_WIDTH must be a multiple of BYTE_W and RD_LATENCY must be 1..3");
  end

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                r_state;
  logic [RAM_DEEP-1:0]   r_clr_cnt;
  logic                  r_init_done;

  logic [RAM_WIDTH-1:0]  r_mem [0:(1<<RAM_DEEP)-1];

  logic [RAM_WIDTH-1:0]  r_old_p1;
  logic [RAM_WIDTH-1:0]  r_wdata_p1;
  logic [NBE-1:0]        r_wbe_p1;
  logic                  r_hit_p1;
  logic                  r_vld_p1;
  logic [RAM_WIDTH-1:0]  r_q_hold;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_clr_we;
  logic [RD_LATENCY-1:0][RAM_WIDTH-1:0] w_q_st;
  logic [RD_LATENCY-1:0]                w_vld_st;

  function automatic logic [RAM_WIDTH-1:0] f_merge(input logic [RAM_WIDTH-1:0] old_w,
                                                   input logic [RAM_WIDTH-1:0] new_w,
                                                   input logic [NBE-1:0]       be,
                                                   input logic                 hit);
    logic [RAM_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (hit && be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  assign w_wr_acc  = wren & r_init_done;
  assign w_rd_acc  = rden & r_init_done;
  assign w_clr_we  = (r_state == S_CLEAR) && (INIT_CLR != 0);
  assign init_done = r_init_done;

  // Init sequencer: sweep every address once, then open the ports
  always_ff @(posedge clk_rd or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (INIT_CLR == 0 || (&r_clr_cnt)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Stage 0 -> p1: array access and capture of the collision context
  always_ff @(posedge clk_rd) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= INIT_VALUE;
    end else if (w_wr_acc) begin
      for (int i = 0; i < NBE; i++) begin
        if (wrbe[i]) r_mem[wraddress][i*BYTE_W +: BYTE_W] <= data[i*BYTE_W +: BYTE_W];
      end
    end
    r_old_p1   <= r_mem[rdaddress];
    r_wdata_p1 <= data;
    r_wbe_p1   <= wrbe;
    r_hit_p1   <= (BYPASS_EN != 0) && w_wr_acc && (wraddress == rdaddress);
  end

  always_ff @(posedge clk_rd or posedge reset) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= w_rd_acc;
  end

  // Stage p1: merge, then optional extra delay stages
  assign w_q_st[0]   = f_merge(r_old_p1, r_wdata_p1, r_wbe_p1, r_hit_p1);
  assign w_vld_st[0] = r_vld_p1;

  for (genvar k = 1; k < RD_LATENCY; k++) begin : g_dly
    logic [RAM_WIDTH-1:0] r_q;
    logic                 r_vld;
    always_ff @(posedge clk_rd) begin
      r_q <= w_q_st[k-1];
    end
    always_ff @(posedge clk_rd or posedge reset) begin
      if (reset) r_vld <= 1'b0;
      else       r_vld <= w_vld_st[k-1];
    end
    assign w_q_st[k]   = r_q;
    assign w_vld_st[k] = r_vld;
  end

  // q shows the fresh result in its valid cycle and the last result otherwise
  always_ff @(posedge clk_rd or posedge reset) begin
    if (reset)      r_q_hold <= '0;
    else if (q_vld) r_q_hold <= w_q_st[RD_LATENCY-1];
  end

  assign q_vld = w_vld_st[RD_LATENCY-1];
  assign q     = q_vld ? w_q_st[RD_LATENCY-1] : r_q_hold;

endmodule

// File: tb/tb_xilinx_sdpram_be.sv
// Bench for xilinx_sdpram_be: two instances (latency 1 with bypass, latency 3 without bypass)
// share one stimulus stream and are compared each cycle against a word-array reference model.
module tb_xilinx_sdpram_be;
  localparam int              W     = 32;
  localparam int              AW    = 4;
  localparam int              NB    = 4;
  localparam int              DEPTH = 16;
  localparam logic [W-1:0]    INITV = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wren = 1'b0, rden = 1'b0;
  logic [AW-1:0] wraddr = '0, rdaddr = '0;
  logic [NB-1:0] wrbe = '0;
  logic [W-1:0]  data = '0;
  logic          done_a, done_b, vld_a, vld_b;
  logic [W-1:0]  q_a, q_b;

  always #5 clk = ~clk;

  xilinx_sdpram_be #(.RAM_WIDTH(W), .RAM_DEEP(AW), .BYTE_W(8), .RD_LATENCY(1),
                     .BYPASS_EN(1), .INIT_CLR(1), .INIT_VALUE(INITV)) u_dut_a (
    .clk_rd(clk), .reset(rst), .init_done(done_a), .wren(wren), .wraddress(wraddr),
    .wrbe(wrbe), .data(data), .rden(rden), .rdaddress(rdaddr), .q(q_a), .q_vld(vld_a));

  xilinx_sdpram_be #(.RAM_WIDTH(W), .RAM_DEEP(AW), .BYTE_W(8), .RD_LATENCY(3),
                     .BYPASS_EN(0), .INIT_CLR(1), .INIT_VALUE(INITV)) u_dut_b (
    .clk_rd(clk), .reset(rst), .init_done(done_b), .wren(wren), .wraddress(wraddr),
    .wrbe(wrbe), .data(data), .rden(rden), .rdaddress(rdaddr), .q(q_b), .q_vld(vld_b));

  typedef struct { int due; logic [W-1:0] val; } rd_t;

  int           checks = 0, failures = 0;
  int           n = 0, m_cnt = 0;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] held_a = '0, held_b = '0;
  rd_t          qa[$], qb[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                              input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Reference: array is all INITV once DEPTH edges have passed since reset release
  task automatic model_edge();
    logic [W-1:0] old_w, new_w;
    n++;
    if (rst) return;
    if (m_cnt >= DEPTH) begin
      if (rden) begin
        old_w = mem[rdaddr];
        new_w = (wren && wraddr == rdaddr) ? lane_merge(old_w, data, wrbe) : old_w;
        qa.push_back(rd_t'{due: n,     val: new_w});
        qb.push_back(rd_t'{due: n + 2, val: old_w});
      end
      if (wren) mem[wraddr] = lane_merge(mem[wraddr], data, wrbe);
    end
    m_cnt++;
  endtask

  task automatic check_outputs();
    logic ev_a, ev_b, exp_done;
    ev_a = 1'b0;
    ev_b = 1'b0;
    if (qa.size() > 0 && qa[0].due == n) begin ev_a = 1'b1; held_a = qa[0].val; void'(qa.pop_front()); end
    if (qb.size() > 0 && qb[0].due == n) begin ev_b = 1'b1; held_b = qb[0].val; void'(qb.pop_front()); end
    exp_done = !rst && (m_cnt >= DEPTH);
    chk("init_done_a", 32'(done_a), 32'(exp_done));
    chk("init_done_b", 32'(done_b), 32'(exp_done));
    chk("q_vld_a", 32'(vld_a), 32'(ev_a));
    chk("q_vld_b", 32'(vld_b), 32'(ev_b));
    chk("q_a", q_a, held_a);
    chk("q_b", q_b, held_b);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic we, input int wa, input logic [NB-1:0] be,
                       input logic [W-1:0] d, input logic re, input int ra);
    wren   = we;
    wraddr = wa[AW-1:0];
    wrbe   = be;
    data   = d;
    rden   = re;
    rdaddr = ra[AW-1:0];
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  task automatic assert_reset();
    #2;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    held_a = '0;
    held_b = '0;
    m_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = INITV;
    #1;
    check_outputs();
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 2 * DEPTH && m_cnt < DEPTH; i++) tick();
  endtask

  task automatic burst_read_all();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 0, '0, '0, 1'b1, a);
      tick();
    end
    idle();
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = INITV;
    idle();
    repeat (3) tick();
    chk("reset_q_a", q_a, '0);
    rst = 1'b0;

    // Accesses during the clear are ignored
    repeat (4) tick();
    drive(1'b1, 2, 4'hF, 32'h1234_5678, 1'b1, 2);
    tick();
    idle();
    wait_clear();
    chk("done_after_clear", 32'(done_a), 32'd1);
    burst_read_all();
    chk("burst_last_a", q_a, INITV);
    chk("burst_last_b", q_b, INITV);

    // Byte-enable partial write
    drive(1'b1, 3, 4'hF, 32'h1122_3344, 1'b0, 0);
    tick();
    drive(1'b1, 3, 4'b0101, 32'hFFEE_DDCC, 1'b0, 0);
    tick();
    drive(1'b0, 0, '0, '0, 1'b1, 3);
    tick();
    idle();
    chk("be_merge_a", q_a, 32'h11EE_33CC);
    repeat (2) tick();
    chk("be_merge_b", q_b, 32'h11EE_33CC);
    repeat (2) tick();

    // Same-address collision
    drive(1'b1, 5, 4'hF, 32'h0, 1'b0, 0);
    tick();
    drive(1'b1, 5, 4'b0011, 32'hDEAD_BEEF, 1'b1, 5);
    tick();
    chk("collide_bypass_a", q_a, 32'h0000_BEEF);
    drive(1'b0, 0, '0, '0, 1'b1, 5);
    tick();
    idle();
    chk("after_collide_a", q_a, 32'h0000_BEEF);
    tick();
    chk("collide_old_b", q_b, 32'h0);
    tick();
    chk("after_collide_b", q_b, 32'h0000_BEEF);
    repeat (2) tick();

    // Randomised traffic with frequent address collisions
    for (int i = 0; i < 400; i++) begin
      int wa;
      wa = int'($urandom_range(0, DEPTH - 1));
      drive(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    idle();
    repeat (4) tick();

    // Reset with reads in flight, then again in the middle of the clear
    drive(1'b0, 0, '0, '0, 1'b1, 1);
    tick();
    drive(1'b0, 0, '0, '0, 1'b1, 2);
    tick();
    assert_reset();
    chk("rst_q_b", q_b, '0);
    idle();
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    assert_reset();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    drive(1'b1, 0, 4'hF, 32'hCAFE_F00D, 1'b1, 0);
    tick();
    idle();
    wait_clear();
    burst_read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
